// File: rtl/radio_pkg.sv
// radio_pkg: frame layout and sync-state definitions shared by the serial link TX and RX sides
package radio_pkg;
  localparam int FRAME_BITS = 8;
  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam int R0_I_MSB = 7;
  localparam int R0_I_LSB = 6;
  localparam int R0_Q_MSB = 5;
  localparam int R0_Q_LSB = 4;
  localparam int R1_I_MSB = 3;
  localparam int R1_I_LSB = 2;
  localparam int R1_Q_MSB = 1;
  localparam int R1_Q_LSB = 0;
  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} sync_state_t;
endpackage

// File: rtl/frame_sync_fsm.sv
// frame_sync_fsm: hunt/check/locked frame alignment tracker with saturating sync error count
module frame_sync_fsm
  import radio_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int MISS_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_in,
  input  logic [CNT_W-1:0] bit_cnt,
  output logic             locked,
  output logic             realign,
  output logic             accept_start,
  output logic [15:0]      err_count
);
  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] MISS_N = 4'(MISS_LIMIT);
  sync_state_t state, state_n;
  logic [3:0] good, good_n, miss, miss_n;
  logic [15:0] err_count_n;
  logic frame_err, frame_err_n, err, frame_end, bad_frame;
  assign locked = state == LOCKED;
  always_comb begin
    err = (bit_cnt == '0) != sync_in;
    frame_end = bit_cnt == CNT_W'(FRAME_BITS - 1);
    bad_frame = frame_err | err;
    state_n = state;
    good_n = good;
    miss_n = miss;
    frame_err_n = frame_err;
    err_count_n = err_count;
    accept_start = 1'b0;
    realign = 1'b0;
    case (state)
      HUNT: if (sync_in) begin
        accept_start = 1'b1;
        good_n = 4'd1;
        state_n = (LOCK_COUNT == 1) ? LOCKED : CHECK;
      end
      CHECK: if (bit_cnt == '0) begin
        good_n = good + 4'd1;
        state_n = !sync_in ? HUNT : (good_n >= LOCK_N) ? LOCKED : CHECK;
      end else if (sync_in) begin
        realign = 1'b1;
        good_n = 4'd1;
      end
      LOCKED: begin
        err_count_n = (err && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
        frame_err_n = !frame_end && bad_frame;
        miss_n = !frame_end ? miss : bad_frame ? miss + 4'd1 : 4'd0;
        state_n = (frame_end && miss_n >= MISS_N) ? HUNT : LOCKED;
      end
      default: state_n = HUNT;
    endcase
    if (state != LOCKED) begin
      miss_n = 4'd0;
      frame_err_n = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= HUNT;
      good <= '0;
      miss <= '0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_n;
      good <= good_n;
      miss <= miss_n;
      frame_err <= frame_err_n;
      err_count <= err_count_n;
    end
endmodule

// File: rtl/radio_frame_deser.sv
// radio_frame_deser: serial I/Q link receiver recovering 8-bit frames into 2-bit I/Q fields
module radio_frame_deser #(
  parameter int LOCK_COUNT = 4,
  parameter int MISS_LIMIT = 3
) (
  input  logic        SYS_CLK,
  input  logic        RST,
  input  logic        DATA_IN,
  input  logic        SYNC_IN,
  output logic [1:0]  R0_I,
  output logic [1:0]  R0_Q,
  output logic [1:0]  R1_I,
  output logic [1:0]  R1_Q,
  output logic        SAMPLE_VALID,
  output logic        LOCKED,
  output logic [15:0] ERR_COUNT
);
  localparam int CW = radio_pkg::CNT_W;
  localparam int FB = radio_pkg::FRAME_BITS;
  logic [CW-1:0] bit_cnt, wr_idx;
  logic [FB-1:0] sreg, sreg_n, frame;
  logic realign, accept_start, start, emit;
  frame_sync_fsm #(.LOCK_COUNT(LOCK_COUNT), .MISS_LIMIT(MISS_LIMIT)) u_fsm (
    .clk(SYS_CLK),
    .rst(RST),
    .sync_in(SYNC_IN),
    .bit_cnt(bit_cnt),
    .locked(LOCKED),
    .realign(realign),
    .accept_start(accept_start),
    .err_count(ERR_COUNT)
  );
  // A (re)aligning sync is frame bit 0, whatever the counter held.
  assign start = accept_start | realign;
  assign wr_idx = start ? '0 : bit_cnt;
  assign emit = LOCKED && bit_cnt == CW'(FB - 1);
  always_comb begin
    sreg_n = sreg;
    sreg_n[wr_idx] = DATA_IN;
  end
  always_ff @(posedge SYS_CLK or posedge RST)
    if (RST) begin
      bit_cnt <= '0;
      sreg <= '0;
      frame <= '0;
      SAMPLE_VALID <= 1'b0;
    end else begin
      bit_cnt <= start ? CW'(1) : bit_cnt + CW'(1);
      sreg <= sreg_n;
      SAMPLE_VALID <= emit;
      if (emit) frame <= sreg_n;
    end
  assign R0_I = frame[radio_pkg::R0_I_MSB:radio_pkg::R0_I_LSB];
  assign R0_Q = frame[radio_pkg::R0_Q_MSB:radio_pkg::R0_Q_LSB];
  assign R1_I = frame[radio_pkg::R1_I_MSB:radio_pkg::R1_I_LSB];
  assign R1_Q = frame[radio_pkg::R1_Q_MSB:radio_pkg::R1_Q_LSB];
endmodule
